// File: rtl/maxnet_param.sv
`default_nettype none
// ============================================================================
// Module   : maxnet_param
// Brief    : Iterative MAXNET winner-take-all over N unsigned channels with
//            lateral inhibition epsilon = 2^-EPS_SHIFT (ceiling-rounded).
// Revision : 1.0 - initial release
// ============================================================================
module maxnet_param #(
    parameter int N         = 4,
    parameter int W         = 5,
    parameter int EPS_SHIFT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N*W-1:0]       X,
    output logic                 busy,
    output logic                 done,
    output logic                 valid,
    output logic [$clog2(N)-1:0] winner_idx,
    output logic [W-1:0]         result,
    output logic [W-1:0]         iter_cnt
);

    localparam int c_xw = $clog2(N);
    localparam int c_sw = W + c_xw;
    localparam int c_iw = c_sw + 1;
    localparam int c_nw = c_xw + 1;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // epsilon must not exceed 1/N, otherwise the network can collapse to zero
    generate
        if (EPS_SHIFT < c_xw) begin : g_eps_check
            $error("maxnet_param: 2^EPS_SHIFT must be >= N");
        end
    endgenerate

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [W-1:0]    r_act     [N];
    logic [W-1:0]    w_act_nxt [N];
    logic [N*W-1:0]  r_x;
    logic [W-1:0]    r_cnt;
    logic [c_sw-1:0] w_sum;
    logic [c_nw-1:0] w_nz_cnt;
    logic [c_xw-1:0] w_nz_idx;
    logic [W-1:0]    w_nz_x;
    logic            w_settled;
    logic            r_valid;
    logic [c_xw-1:0] r_idx;
    logic [W-1:0]    r_result;
    logic [W-1:0]    r_iter;

    // Sum of activations plus the identity of the (last) nonzero channel;
    // the identity is only meaningful when exactly one channel survives.
    always_comb begin
        w_sum    = '0;
        w_nz_cnt = '0;
        w_nz_idx = '0;
        w_nz_x   = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = w_sum + c_sw'(r_act[i]);
            if (r_act[i] != '0) begin
                w_nz_cnt = w_nz_cnt + c_nw'(1);
                w_nz_idx = c_xw'(i);
                w_nz_x   = r_x[i*W +: W];
            end
        end
    end

    assign w_settled = (w_nz_cnt <= c_nw'(1));

    generate
        for (genvar i = 0; i < N; i++) begin : g_chan
            logic [c_iw-1:0] w_diff;
            logic [c_iw-1:0] w_inh;
            assign w_diff = c_iw'(w_sum) - c_iw'(r_act[i]);
            // ceil(diff / 2^EPS_SHIFT) without an add-then-shift overflow
            assign w_inh  = (w_diff == '0) ? '0
                          : ((w_diff - c_iw'(1)) >> EPS_SHIFT) + c_iw'(1);
            assign w_act_nxt[i] = (w_inh >= c_iw'(r_act[i])) ? '0
                                : (r_act[i] - w_inh[W-1:0]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (start) w_state_nxt = c_st_run;
            c_st_run:  if (w_settled) w_state_nxt = c_st_done;
            c_st_done: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_act[i] <= '0;
            end
            r_x      <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_iter   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            r_act[i] <= X[i*W +: W];
                        end
                        r_x   <= X;
                        r_cnt <= '0;
                    end
                end
                c_st_run: begin
                    if (w_settled) begin
                        r_valid  <= (w_nz_cnt == c_nw'(1));
                        r_idx    <= w_nz_idx;
                        r_result <= w_nz_x;
                        r_iter   <= r_cnt;
                    end else begin
                        for (int i = 0; i < N; i++) begin
                            r_act[i] <= w_act_nxt[i];
                        end
                        r_cnt <= r_cnt + W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state != c_st_idle);
    assign done       = (r_state == c_st_done);
    assign valid      = r_valid;
    assign winner_idx = r_idx;
    assign result     = r_result;
    assign iter_cnt   = r_iter;

endmodule
`default_nettype wire

// File: tb/tb_maxnet_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_maxnet_param
// Brief    : Directed self-checking bench for maxnet_param (N=4, W=5, EPS=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_maxnet_param;

    localparam int N = 4;
    localparam int W = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N*W-1:0] X;
    logic           busy;
    logic           done;
    logic           valid;
    logic [1:0]     winner_idx;
    logic [W-1:0]   result;
    logic [W-1:0]   iter_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;
    int pulses;

    maxnet_param #(.N(N), .W(W), .EPS_SHIFT(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .X          (X),
        .busy       (busy),
        .done       (done),
        .valid      (valid),
        .winner_idx (winner_idx),
        .result     (result),
        .iter_cnt   (iter_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [N*W-1:0] pack(input int c0, input int c1, input int c2, input int c3);
        return {W'(c3), W'(c2), W'(c1), W'(c0)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int v, input int idx, input int res, input int it);
        chk({tag, ".valid"},      32'(valid),      32'(v));
        chk({tag, ".winner_idx"}, 32'(winner_idx), 32'(idx));
        chk({tag, ".result"},     32'(result),     32'(res));
        chk({tag, ".iter_cnt"},   32'(iter_cnt),   32'(it));
    endtask

    // Returns the edge number (start edge = 0) after which done is high; -1 on timeout
    task automatic wait_done(output int l);
        l = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (done) begin
                l = c;
                break;
            end
        end
    endtask

    task automatic start_comp(input logic [N*W-1:0] x);
        @(negedge clk);
        X     = x;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_case(input string tag, input logic [N*W-1:0] x, input int exp_lat,
                            input int v, input int idx, input int res, input int it);
        int l;
        start_comp(x);
        chk({tag, ".busy_run"}, 32'(busy), 32'd1);
        wait_done(l);
        chk({tag, ".latency"}, 32'(l), 32'(exp_lat));
        chk_outs(tag, v, idx, res, it);
        @(negedge clk);
        chk({tag, ".done_width"}, 32'(done), 32'd0);
        chk({tag, ".busy_idle"},  32'(busy), 32'd0);
    endtask

    task automatic count_done(input int cycles, output int p);
        p = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (done) p++;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        X     = pack(1, 2, 3, 4);
        repeat (2) @(negedge clk);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk_outs("reset", 0, 0, 0, 0);
        start = 1'b0;
        rst   = 1'b0;

        run_case("c1234", pack(1, 2, 3, 4),   4, 1, 3, 4, 3);
        run_case("c0070", pack(0, 0, 7, 0),   1, 1, 2, 7, 0);
        run_case("tie",   pack(5, 5, 2, 1),   6, 0, 0, 0, 5);
        run_case("zero",  pack(0, 0, 0, 0),   1, 0, 0, 0, 0);
        run_case("wide",  pack(31, 30, 0, 0), 15, 1, 0, 31, 14);

        X = pack(3, 3, 3, 3);
        repeat (3) @(negedge clk);
        chk_outs("hold", 1, 0, 31, 14);

        // restart attempt and input change while running
        @(negedge clk);
        X     = pack(1, 2, 3, 4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        X     = pack(0, 0, 31, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("busy_start.latency", 32'(lat), 32'd2);
        chk_outs("busy_start", 1, 3, 4, 3);
        count_done(10, pulses);
        chk("busy_start.extra_done", 32'(pulses), 32'd0);

        // abort two cycles into RUN
        @(negedge clk);
        X     = pack(1, 2, 3, 4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk_outs("abort", 0, 0, 0, 0);
        rst = 1'b0;
        count_done(6, pulses);
        chk("abort.no_done", 32'(pulses), 32'd0);
        run_case("after_abort", pack(1, 2, 3, 4), 4, 1, 3, 4, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/maxnet_param.md
MAXNET_PARAM -- requirements
Module: maxnet_param

Interface
REQ-001 Parameter N, default 4: number of competing channels; legal range N >= 2.
REQ-002 Parameter W, default 5: unsigned activation width per channel; legal range W >= 2.
REQ-003 Parameter EPS_SHIFT, default 3: inhibition factor epsilon = 2^-EPS_SHIFT; SHALL satisfy 2^EPS_SHIFT >= N, and elaboration SHALL fail otherwise.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 start  input  1  request a competition; sampled only in IDLE.
REQ-007 X  input  N*W  packed unsigned inputs; channel i = X[i*W +: W], channel 0 at the LSBs.
REQ-008 busy  output  1  high while a competition is in progress (RUN and DONE states).
REQ-009 done  output  1  one-cycle pulse marking the end of a competition.
REQ-010 valid  output  1  exactly one channel survived.
REQ-011 winner_idx  output  clog2(N)  index of the surviving channel.
REQ-012 result  output  W  original input value of the winning channel.
REQ-013 iter_cnt  output  W  number of update iterations performed.

Function
REQ-014 FSM SHALL have states IDLE, RUN, DONE.
REQ-015 IDLE with start=1: all N activations a_i <= X_i, iteration counter <= 0, all X_i latched, next state RUN; otherwise the FSM stays in IDLE.
REQ-016 RUN, nonzero-activation count <= 1: no update; outputs captured; next state DONE.
REQ-017 RUN, count >= 2: all channels update in parallel in one cycle; counter increments; FSM stays in RUN.
REQ-018 Update rule: S = sum of all a_j at width W+clog2(N); inh_i = ceil((S - a_i) / 2^EPS_SHIFT), computed as (S - a_i + 2^EPS_SHIFT - 1) >> EPS_SHIFT at width W+clog2(N)+1; a_i <= (inh_i >= a_i) ? 0 : a_i - inh_i.
REQ-019 Every nonzero channel SHALL decrease by at least 1 per update; the iteration count is therefore bounded by 2^W - 1 and iter_cnt SHALL NOT overflow.
REQ-020 A unique maximum input SHALL always be the survivor.
REQ-021 Tied maxima SHALL fall to zero together, giving valid=0.
REQ-022 On entry to DONE with exactly one nonzero channel k: valid=1, winner_idx=k, result=latched X_k, iter_cnt=counter.
REQ-023 On entry to DONE with zero nonzero channels: valid=0, winner_idx=0, result=0, iter_cnt=counter.
REQ-024 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-025 Latency: with start sampled at edge 0 and k update iterations, done SHALL be high in the cycle following edge k+1.
REQ-026 start while busy (RUN or DONE) SHALL be ignored and SHALL NOT queue.
REQ-027 Changes on X after the start-sampling edge SHALL have no effect on the running competition.
REQ-028 valid, winner_idx, result and iter_cnt SHALL hold their values from the end of one competition until the end of the next.
REQ-029 busy SHALL be 0 in IDLE and 1 in RUN and DONE.

Reset
REQ-030 rst=1 at a clock edge: state IDLE; all activations, counter, latched inputs and every output (busy, done, valid, winner_idx, result, iter_cnt) SHALL be 0.
REQ-031 rst SHALL take priority over start and over any in-progress competition; no done pulse SHALL be produced for an aborted competition.

Verification (N=4, W=5, EPS_SHIFT=3)
REQ-032 X=(ch0..ch3)=(1,2,3,4), start pulse -> done high after edge 4; valid=1, winner_idx=3, result=4, iter_cnt=3.
REQ-033 X=(0,0,7,0) -> done high after edge 1; valid=1, winner_idx=2, result=7, iter_cnt=0.
REQ-034 X=(5,5,2,1), then X=(0,0,0,0) -> valid=0, result=0, winner_idx=0 in both cases; the all-zero case gives iter_cnt=0.
REQ-035 X=(31,30,0,0) -> valid=1, winner_idx=0, result=31; iter_cnt <= 31.
REQ-036 Start (1,2,3,4); X changed and start re-pulsed during RUN -> original result unchanged, exactly one done pulse.
REQ-037 rst asserted 2 cycles into RUN -> all outputs 0, no done pulse; a following start on (1,2,3,4) completes normally.
